multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Sequences the multi-cycle mult/div unit from the X stage of the 5-stage pipeline. Detects mul/div in the D/X
//  latch, pulses the unit's start control, freezes PC/F-D/D-X and bubbles X/M until the unit reports ready.
//  It then steers the result, or the rstatus ($30) exception code, into X/M for writeback.
// PARAMETERS
//  TIMEOUT_CYCLES  40  max BUSY cycles before forced abort (watchdog)
//  CNT_W           6   busy-counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clock           in   1   master clock, rising edge
//  reset           in   1   synchronous, active-high
//  ex_opcode       in   5   D/X insn [31:27]
//  ex_aluop        in   5   D/X insn [6:2]
//  ex_rd           in   5   D/X insn [26:22]
//  md_result_rdy   in   1   unit result valid (level)
//  md_exception    in   1   unit overflow / div-by-zero, valid with md_result_rdy
//  md_ctrl_mult    out  1   one-cycle start pulse, multiply
//  md_ctrl_div     out  1   one-cycle start pulse, divide
//  stall           out  1   hold PC, F/D, D/X latches (enable=0)
//  bubble_xm       out  1   load nop into X/M this edge
//  md_done         out  1   X/M O-latch selects md result / status this edge
//  md_wb_en        out  1   writeback enable for the md instruction
//  md_wb_reg       out  5   destination: ex_rd, or 5'd30 on exception/timeout
//  md_status_val   out  32  rstatus value: 4 mult, 5 div; 0 when no exception
//  md_timeout      out  1   high in DONE if watchdog fired
// BEHAVIOUR
//  - Decode: is_mult = opcode==00000 && aluop==00110; is_div = opcode==00000 && aluop==00111.
//  - FSM states IDLE, BUSY, DONE. Reset (sync): state=IDLE, counter=0, latched op/exc/timeout=0. All outputs 0
//    except when combinationally driven in IDLE by a pending op (below).
//  - IDLE: if is_mult|is_div -> assert md_ctrl_mult/div and stall=bubble_xm=1 combinationally; latch op type.
//    Next state BUSY, counter=0. Otherwise stall=0, no pulse.
//  - BUSY: stall=bubble_xm=1; counter++. If md_result_rdy: latch md_exception; next state DONE.
//    Else if counter==TIMEOUT_CYCLES-1: set timeout flag; next state DONE.
//  - DONE (exactly 1 cycle): stall=0, bubble_xm=0, md_done=1. Next state IDLE.
//    - exception|timeout: md_wb_en=1, md_wb_reg=30, md_status_val=4/5 by op, md_timeout=timeout.
//    - else: md_wb_en=(ex_rd!=0), md_wb_reg=ex_rd, md_status_val=0.
//  - Latency: start pulse in cycle c0; rdy seen in cycle c0+N (N>=1) -> DONE in c0+N+1; stall high c0..c0+N.
//  - Boundaries:
//    - md_result_rdy in IDLE or DONE is ignored.
//    - Start cycle ignores rdy (unit never ready in 0 cycles).
//    - The md insn still sits in D/X during DONE; DONE never starts a new op.
//    - Back-to-back md ops start in the IDLE cycle right after DONE.
//    - rdy and timeout in the same cycle: rdy wins, timeout flag not set.
//    - Counter saturates and never wraps.
//    - Reset in BUSY/DONE: abandon op, no writeback, IDLE next cycle. A md insn still in D/X restarts normally.
// STRUCTURE
//  - Shared header multdiv_defs.vh: state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), ALU_MULT=5'b00110,
//    ALU_DIV=5'b00111, OP_RTYPE=5'b00000, REG_RSTATUS=5'd30, STATUS_MULT=32'd4, STATUS_DIV=32'd5.
//  - Sub-module md_busy_counter: CNT_W-bit saturating counter with sync clear and terminal-count flag.
//  - FSM state register uses the codebase register cell on clock, reset as clr.
// TESTING
//  1. mult, rd=3, rdy at c0+17 -> md_ctrl_mult=1 only in c0; stall c0..c0+17; DONE c0+18, wb_en=1, wb_reg=3,
//     status_val=0.
//  2. div, rdy+exception at c0+5 -> DONE c0+6: wb_reg=30, status_val=5, wb_en=1, md_timeout=0.
//  3. mult, rdy never -> DONE at c0+41 with md_timeout=1, wb_reg=30, status_val=4; IDLE at c0+42.
//  4. reset asserted at c0+8 of BUSY -> c0+9: IDLE, md_wb_en=0; mult still in D/X retriggers the pulse at c0+9.
//  5. Two back-to-back mults, rdy at N=3 each -> pulses at c0 and c0+5; stall low only in c0+4.
//  6. mult rd=0, no exception -> DONE with md_wb_en=0; rdy held high through IDLE -> no spurious start or done.

Source files
------------

// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings for the mult/div sequencer: FSM states, decode fields,
// and the rstatus register and status codes.
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

  localparam logic [4:0]  OP_RTYPE    = 5'b00000;
  localparam logic [4:0]  ALU_MULT    = 5'b00110;
  localparam logic [4:0]  ALU_DIV     = 5'b00111;
  localparam logic [4:0]  REG_RSTATUS = 5'd30;
  localparam logic [31:0] STATUS_MULT = 32'd4;
  localparam logic [31:0] STATUS_DIV  = 32'd5;

endpackage

// File: rtl/multdiv_sequencer_busy_counter.sv
// Saturating busy-cycle counter with synchronous clear and a terminal-count
// flag that is raised while the count equals TC_VAL.
module md_busy_counter #(
  parameter int CNT_W  = 6,
  parameter int TC_VAL = 39
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TC_VAL);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != CNT_MAX))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == CNT_TC);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the multi-cycle mult/div unit from the X stage: pulses the start
// control, holds the front of the pipe, then steers result/status into X/M.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ex_opcode,
  input  logic [4:0]  ex_aluop,
  input  logic [4:0]  ex_rd,
  input  logic        md_result_rdy,
  input  logic        md_exception,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        stall,
  output logic        bubble_xm,
  output logic        md_done,
  output logic        md_wb_en,
  output logic [4:0]  md_wb_reg,
  output logic [31:0] md_status_val,
  output logic        md_timeout
);

  md_state_e r_state, w_next;
  logic      r_op_div, r_exc, r_tmo;
  logic      w_is_mult, w_is_div, w_start, w_tc;

  assign w_is_mult = (ex_opcode == OP_RTYPE) && (ex_aluop == ALU_MULT);
  assign w_is_div  = (ex_opcode == OP_RTYPE) && (ex_aluop == ALU_DIV);
  assign w_start   = w_is_mult || w_is_div;

  // Counter only runs in BUSY; first BUSY cycle sees count 0.
  md_busy_counter #(
    .CNT_W  (CNT_W),
    .TC_VAL (TIMEOUT_CYCLES - 1)
  ) u_busy_cnt (
    .clock (clock),
    .reset (reset),
    .i_clr (r_state != ST_BUSY),
    .i_inc (r_state == ST_BUSY),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op_div <= 1'b0;
      r_exc    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_op_div <= w_is_div;
          r_exc    <= 1'b0;
          r_tmo    <= 1'b0;
        end
        ST_BUSY: begin
          // rdy takes priority over the watchdog in the same cycle
          if (md_result_rdy) r_exc <= md_exception;
          else if (w_tc)     r_tmo <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next        = r_state;
    md_ctrl_mult  = 1'b0;
    md_ctrl_div   = 1'b0;
    stall         = 1'b0;
    bubble_xm     = 1'b0;
    md_done       = 1'b0;
    md_wb_en      = 1'b0;
    md_wb_reg     = 5'd0;
    md_status_val = 32'd0;
    md_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) begin
        md_ctrl_mult = w_is_mult;
        md_ctrl_div  = w_is_div;
        stall        = 1'b1;
        bubble_xm    = 1'b1;
        w_next       = ST_BUSY;
      end
      ST_BUSY: begin
        stall     = 1'b1;
        bubble_xm = 1'b1;
        if (md_result_rdy || w_tc) w_next = ST_DONE;
      end
      ST_DONE: begin
        md_done = 1'b1;
        w_next  = ST_IDLE;
        if (r_exc || r_tmo) begin
          md_wb_en      = 1'b1;
          md_wb_reg     = REG_RSTATUS;
          md_status_val = r_op_div ? STATUS_DIV : STATUS_MULT;
          md_timeout    = r_tmo;
        end else begin
          md_wb_en  = (ex_rd != 5'd0);
          md_wb_reg = ex_rd;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: per-cycle control checks in the
// driver, writeback payload checked against a queue when md_done fires.
module tb_multdiv_sequencer;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] status;
    logic        tmo;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ex_opcode, ex_aluop, ex_rd;
  logic        md_result_rdy, md_exception;
  logic        md_ctrl_mult, md_ctrl_div, stall, bubble_xm, md_done;
  logic        md_wb_en, md_timeout;
  logic [4:0]  md_wb_reg;
  logic [31:0] md_status_val;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  multdiv_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .ex_opcode(ex_opcode), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
    .md_result_rdy(md_result_rdy), .md_exception(md_exception),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .stall(stall), .bubble_xm(bubble_xm), .md_done(md_done),
    .md_wb_en(md_wb_en), .md_wb_reg(md_wb_reg),
    .md_status_val(md_status_val), .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  // Writeback payload monitor
  always @(negedge clock) begin
    if (!reset && md_done) begin
      if (sb.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_en",  {31'd0, md_wb_en},   {31'd0, e.wb_en});
        chk("wb_reg", {27'd0, md_wb_reg},  {27'd0, e.wb_reg});
        chk("status", md_status_val,       e.status);
        chk("tmo",    {31'd0, md_timeout}, {31'd0, e.tmo});
      end
    end
  end

  // One cycle: inputs already set; check controls at negedge, step past posedge.
  task automatic cyc(input string tag, input bit e_stall, input bit e_mult,
                     input bit e_div, input bit e_done);
    @(negedge clock);
    chk({tag, "_stall"},  {31'd0, stall},        {31'd0, e_stall});
    chk({tag, "_bubble"}, {31'd0, bubble_xm},    {31'd0, e_stall});
    chk({tag, "_mult"},   {31'd0, md_ctrl_mult}, {31'd0, e_mult});
    chk({tag, "_div"},    {31'd0, md_ctrl_div},  {31'd0, e_div});
    chk({tag, "_done"},   {31'd0, md_done},      {31'd0, e_done});
    if (!e_done) chk({tag, "_wbidle"}, {31'd0, md_wb_en}, 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic set_nop();
    ex_opcode = 5'd0; ex_aluop = 5'd0; ex_rd = 5'd0;
    md_result_rdy = 1'b0; md_exception = 1'b0;
  endtask

  // Issue an md op with rdy at offset n (or never, if tmo); insn stays in D/X through DONE.
  task automatic run_op(input bit is_div, input logic [4:0] rd, input int n,
                        input bit exc, input bit tmo);
    exp_t e;
    int   last;
    ex_opcode = 5'd0; ex_aluop = is_div ? 5'b00111 : 5'b00110; ex_rd = rd;
    if (exc || tmo) begin
      e.wb_en = 1'b1; e.wb_reg = 5'd30; e.status = is_div ? 32'd5 : 32'd4; e.tmo = tmo;
    end else begin
      e.wb_en = (rd != 5'd0); e.wb_reg = rd; e.status = 32'd0; e.tmo = 1'b0;
    end
    sb.push_back(e);
    last = tmo ? 40 : n;
    for (int k = 0; k <= last; k++) begin
      md_result_rdy = !tmo && (k == n);
      md_exception  = exc && (k == n);
      cyc("busy", 1'b1, (k == 0) && !is_div, (k == 0) && is_div, 1'b0);
    end
    md_result_rdy = 1'b0; md_exception = 1'b0;
    cyc("done", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    set_nop();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("rst_wbreg",  {27'd0, md_wb_reg}, 32'd0);
    chk("rst_status", md_status_val,      32'd0);
    chk("rst_tmo",    {31'd0, md_timeout}, 32'd0);
    @(posedge clock); #1;

    // non-R-type with mult aluop must not start
    ex_opcode = 5'd1; ex_aluop = 5'b00110; ex_rd = 5'd3;
    cyc("notr", 1'b0, 1'b0, 1'b0, 1'b0);
    set_nop();

    run_op(1'b0, 5'd3, 17, 1'b0, 1'b0);   // mult, rdy at c0+17
    set_nop(); cyc("gap1", 1'b0, 1'b0, 1'b0, 1'b0);

    run_op(1'b1, 5'd9, 5, 1'b1, 1'b0);    // div, exception
    set_nop(); cyc("gap2", 1'b0, 1'b0, 1'b0, 1'b0);

    run_op(1'b0, 5'd4, 0, 1'b0, 1'b1);    // mult, watchdog
    set_nop(); cyc("gap3", 1'b0, 1'b0, 1'b0, 1'b0);

    run_op(1'b0, 5'd11, 40, 1'b0, 1'b0);  // rdy coincides with watchdog: rdy wins
    set_nop(); cyc("gap4", 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-BUSY abandons the op; mult still in D/X restarts at once
    ex_opcode = 5'd0; ex_aluop = 5'b00110; ex_rd = 5'd7;
    for (int k = 0; k < 8; k++) cyc("prerst", 1'b1, k == 0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc("inrst", 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    run_op(1'b0, 5'd7, 4, 1'b0, 1'b0);
    set_nop(); cyc("gap5", 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back mults: second pulse right after DONE
    run_op(1'b0, 5'd5, 3, 1'b0, 1'b0);
    run_op(1'b0, 5'd5, 3, 1'b0, 1'b0);
    set_nop(); cyc("gap6", 1'b0, 1'b0, 1'b0, 1'b0);

    // rd=0 no writeback; then rdy held high in IDLE is ignored
    run_op(1'b0, 5'd0, 2, 1'b0, 1'b0);
    set_nop();
    md_result_rdy = 1'b1; md_exception = 1'b1;
    for (int k = 0; k < 4; k++) cyc("rdyidle", 1'b0, 1'b0, 1'b0, 1'b0);
    set_nop();

    // div after stray rdy: normal completion without exception
    run_op(1'b1, 5'd31, 1, 1'b0, 1'b0);
    set_nop(); cyc("gap7", 1'b0, 1'b0, 1'b0, 1'b0);

    chk("sb_left", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
